adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one saturating signed `adder` instance between `NREQ` requesters through a round-robin arbiter. Each requester presents an operand pair over a valid/ready handshake. Results return on a single tagged response channel through a one-deep output register. It sits between the processing lanes and the shared arithmetic resource, and provides single-cycle latency and full throughput when the response side is not stalled.

## Interface
- `DATAW`, 8, operand/result width (signed, two's complement)
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, derived; width of requester id
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  NREQ  per-requester request valid
- `req_ready_o`  out  NREQ  per-requester grant/accept; at most one bit high
- `req_a_i`  in  NREQ×DATAW  operand a per requester
- `req_b_i`  in  NREQ×DATAW  operand b per requester
- `resp_valid_o`  out  1  result valid
- `resp_ready_i`  in  1  consumer accepts result
- `resp_id_o`  out  IDW  index of requester that produced the result
- `resp_sum_o`  out  DATAW  saturated sum

## Operation
- **Sum rule:** exact sum a+b, clamped to [−2^(DATAW−1), 2^(DATAW−1)−1]. It is computed by one combinational `adder` instance fed from the granted requester's operands.
- **Output state machine:**
  - EMPTY: `resp_valid_o`=0.
  - FULL: `resp_valid_o`=1; `resp_id_o` and `resp_sum_o` stable.
- **Slot free** = EMPTY, or FULL with `resp_ready_i`=1 (drain).
- **Grant:** when the slot is free and any `req_valid_i` is high, exactly one `req_ready_o` bit goes high.
  - The grant goes to the first valid index found searching upward, with wrap, from `ptr`.
  - The handshake completes on that edge. The register loads id and sum, and the state becomes FULL.
- **Transitions:**
  - EMPTY→FULL on grant.
  - FULL→EMPTY on drain without a new grant.
  - FULL→FULL on drain with a simultaneous grant (back-to-back, no bubble).
  - FULL stays FULL under stall: `resp_ready_i`=0, all `req_ready_o`=0, outputs held.
- **Pointer:** `ptr` updates to (granted index + 1) mod NREQ on each grant, and is unchanged otherwise.
- **Combinational paths:** `req_ready_o` depends combinationally on `req_valid_i`, `resp_ready_i` and state. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- **Request stability:** once raised, a requester holds `req_valid_i` and its operands until accepted. The block does not check this.

## Timing
- **Reset values:** `resp_valid_o`=0, `resp_id_o`=0, `resp_sum_o`=0, `ptr`=0. `req_ready_o` is all-zero while `rst_ni`=0.
- **Latency:** a request accepted at edge t gives `resp_valid_o`=1 immediately after edge t.
- **Throughput:** one result per cycle with `resp_ready_i` held high.
- **Reset mid-operation:** asynchronous. A held result is discarded, state goes to EMPTY and `ptr` goes to 0 immediately. The first grant can occur on the first edge after deassertion.

## Configuration
- `ADDER_ARB_SAT_FLAG_EN`
  - Defined: adds output `resp_sat_o` (1 bit, reset 0), registered alongside the sum. It is 1 when clamping occurred for that result.
  - Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- **Package `adder_arb_pkg`:** output-state enum (EMPTY, FULL) and a response struct (id, sum, optional sat).
- **Sub-module `adder_arb_rr`:** purely combinational round-robin grant logic. Takes valid vector, `ptr` and enable; returns one-hot grant and granted index.
- **Pointer register:** kept in the parent, not in `adder_arb_rr`.
- **Shared adder:** the existing `adder` module, instantiated once.

## Test plan
All scenarios use DATAW=8, NREQ=4.

- **Single request:** after reset, req1 valid with a=124, b=4 → `req_ready_o`=0010 that cycle; next cycle `resp_valid_o`=1, id=1, sum=127, and `resp_sat_o`=1 if the flag is enabled.
- **All four valid, consumer ready:** all four valid from reset with `resp_ready_i`=1, operands (0,0), (1,2), (8,−8), (−127,−2) → grants 0,1,2,3 on consecutive cycles; results 0, 3, 0, −128 with ids 0..3 and no bubbles.
- **Fairness:** req0 and req2 held valid continuously → grants alternate 0,2,0,2.
- **Backpressure:** `resp_ready_i`=0 for 3 cycles while FULL with req3 valid → outputs stable and `req_ready_o`=0000. `resp_ready_i` rises → drain and req3 grant on the same edge; next result id=3.
- **Reset mid-operation:** `rst_ni` pulled low mid-cycle while FULL → `resp_valid_o`=0 without waiting for a clock edge. After release with req1 and req3 valid → first grant goes to req1 (`ptr`=0).

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types for adder_arbiter: output-slot state and the registered response.
// ADDER_ARB_SAT_FLAG_EN adds a saturation flag to the response struct.
package adder_arb_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned NReq  = 4;
    localparam int unsigned IdW   = $clog2(NReq);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } out_state_e;

    // Sized from the package constants; the top's parameter defaults come from here too.
    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] sum;
`ifdef ADDER_ARB_SAT_FLAG_EN
        logic             sat;
`endif
    } resp_t;

endpackage

// File: rtl/adder.sv
// Combinational saturating signed adder; sat_o flags that the sum was clamped.
module adder #(
    parameter int unsigned DATAW = 8
) (
    input  logic signed [DATAW-1:0] a_i,
    input  logic signed [DATAW-1:0] b_i,
    output logic signed [DATAW-1:0] sum_o,
    output logic                    sat_o
);

    logic [DATAW:0] ext;

    always_comb begin
        ext   = {a_i[DATAW-1], a_i} + {b_i[DATAW-1], b_i};
        // Overflow iff the two top bits of the widened sum disagree.
        sat_o = ext[DATAW] ^ ext[DATAW-1];
        sum_o = ext[DATAW-1:0];
        if (sat_o) begin
            sum_o = {ext[DATAW], {(DATAW-1){~ext[DATAW]}}};
        end
    end

endmodule

// File: rtl/adder_arb_rr.sv
// Combinational round-robin pick: first valid index at or above ptr_i, wrapping.
module adder_arb_rr #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand  = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_i) + i) % NREQ;
            if (!found && valid_i[cand]) begin
                found = 1'b1;
                idx_o = IDW'(cand);
            end
        end
        gnt_o[idx_o] = en_i & found;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one saturating adder between NREQ requesters, one-deep tagged output.
// Optional ADDER_ARB_SAT_FLAG_EN adds resp_sat_o (registered clamp indicator).
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned DATAW = DataW,
    parameter int unsigned NREQ  = NReq,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ-1:0][DATAW-1:0] req_a_i,
    input  logic [NREQ-1:0][DATAW-1:0] req_b_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [IDW-1:0]             resp_id_o,
`ifdef ADDER_ARB_SAT_FLAG_EN
    output logic                       resp_sat_o,
`endif
    output logic [DATAW-1:0]           resp_sum_o
);

    out_state_e state_q, state_d;
    resp_t      resp_q, resp_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic             slot_free;
    logic             any_gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [DATAW-1:0] add_sum;
    logic             add_sat;

    // Gate with reset so no handshake is offered while rst_ni is low.
    assign slot_free = rst_ni & ((state_q == StEmpty) | resp_ready_i);
    assign any_gnt   = |req_ready_o;

    adder_arb_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (slot_free),
        .gnt_o   (req_ready_o),
        .idx_o   (gnt_idx)
    );

    adder #(
        .DATAW (DATAW)
    ) u_adder (
        .a_i   (req_a_i[gnt_idx]),
        .b_i   (req_b_i[gnt_idx]),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

`ifndef ADDER_ARB_SAT_FLAG_EN
    logic unused_add_sat;
    assign unused_add_sat = add_sat;
`endif

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        ptr_d   = ptr_q;
        if (any_gnt) begin
            state_d    = StFull;
            resp_d.id  = gnt_idx;
            resp_d.sum = add_sum;
`ifdef ADDER_ARB_SAT_FLAG_EN
            resp_d.sat = add_sat;
`endif
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == StFull && resp_ready_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            resp_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            ptr_q   <= ptr_d;
        end
    end

    assign resp_valid_o = (state_q == StFull);
    assign resp_id_o    = resp_q.id;
    assign resp_sum_o   = resp_q.sum;
`ifdef ADDER_ARB_SAT_FLAG_EN
    assign resp_sat_o   = resp_q.sat;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with an arbitration model and a response scoreboard.
// Build with ADDER_ARB_SAT_FLAG_EN defined to also check resp_sat_o.
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int DATAW = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       sat;
    } exp_t;

    logic                       clk;
    logic                       rst_ni;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][DATAW-1:0] req_a;
    logic [NREQ-1:0][DATAW-1:0] req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [1:0]                 resp_id;
    logic [DATAW-1:0]           resp_sum;
`ifdef ADDER_ARB_SAT_FLAG_EN
    logic                       resp_sat;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic m_full;
    int   m_ptr;
    logic auto_drop;

    adder_arbiter #(
        .DATAW (DATAW),
        .NREQ  (NREQ)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
`ifdef ADDER_ARB_SAT_FLAG_EN
        .resp_sat_o   (resp_sat),
`endif
        .resp_sum_o   (resp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_sum(input int id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s;
        s     = int'($signed(a)) + int'($signed(b));
        e.id  = 2'(id);
        e.sat = (s > 127) || (s < -128);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        e.sum = 8'(s);
        return e;
    endfunction

    function automatic int arb(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // One clock: sample at negedge, predict grant, score the held result, advance model.
    task automatic cycle();
        int g;
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            check("resp_id", 32'(resp_id), 32'(sb[0].id));
            check("resp_sum", 32'(resp_sum), 32'(sb[0].sum));
`ifdef ADDER_ARB_SAT_FLAG_EN
            check("resp_sat", 32'(resp_sat), 32'(sb[0].sat));
`endif
        end
        g = (!m_full || resp_ready) ? arb(req_valid, m_ptr) : -1;
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (m_full && resp_ready && sb.size() > 0) void'(sb.pop_front());
        if (g >= 0) begin
            sb.push_back(model_sum(g, req_a[g], req_b[g]));
            m_ptr = (g + 1) % NREQ;
        end
        m_full = (g >= 0) || (m_full && !resp_ready);
        @(posedge clk);
        #1;
        if (auto_drop && g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_sum", 32'(resp_sum), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
`ifdef ADDER_ARB_SAT_FLAG_EN
        check("rst_sat", 32'(resp_sat), 32'd0);
`endif
        sb.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        auto_drop  = 1'b1;
        m_full     = 1'b0;
        m_ptr      = 0;

        // Single request with positive saturation.
        do_reset();
        req_valid = '0;
        req_a[1]  = 8'd124;
        req_b[1]  = 8'd4;
        req_valid = 4'b0010;
        cycle();
        cycle();

        // All four valid, no bubbles, negative clamp on the last.
        do_reset();
        req_a     = {8'(-127), 8'd8, 8'd1, 8'd0};
        req_b     = {8'(-2), 8'(-8), 8'd2, 8'd0};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) cycle();

        // Fairness between req0 and req2 held continuously.
        do_reset();
        auto_drop = 1'b0;
        req_a[0]  = 8'd10;
        req_b[0]  = 8'd20;
        req_a[2]  = 8'(-50);
        req_b[2]  = 8'(-100);
        req_valid = 4'b0101;
        for (int i = 0; i < 4; i++) cycle();

        // Backpressure with req3 waiting, then drain and grant on the same edge.
        auto_drop  = 1'b1;
        req_valid  = 4'b1000;
        req_a[3]   = 8'd100;
        req_b[3]   = 8'd27;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        resp_ready = 1'b1;
        cycle();
        cycle();

        // Asynchronous reset while FULL, then restart from ptr 0.
        req_a[0]   = 8'd5;
        req_b[0]   = 8'd6;
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        cycle();
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        m_full     = 1'b0;
        m_ptr      = 0;
        req_a[1]   = 8'd7;
        req_b[1]   = 8'd9;
        req_a[3]   = 8'd1;
        req_b[3]   = 8'd1;
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        #1;
        rst_ni = 1'b1;
        cycle();
        cycle();
        cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
